uart_rx: RTL and testbench

- UART receiver; counterpart of the team's UART transmitter, with the same baud_set encoding.
- Samples an asynchronous serial line at 16x the baud rate and recovers 8N1 frames (1 start, 8 data LSB first, 1 stop).
- Presents each byte with a one-cycle done pulse and a framing-error flag.
- Sits between the board RX pin and byte-level consumers (FIFO, command parser).

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote per bit,
// one-cycle rx_done / frame_err pulses. baud_set encoding matches uart_tx.
module uart_rx #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic [2:0] baud_set,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);
    localparam int DIV0 = (CLK_FREQ + 8*9600)   / (16*9600);
    localparam int DIV1 = (CLK_FREQ + 8*19200)  / (16*19200);
    localparam int DIV2 = (CLK_FREQ + 8*38400)  / (16*38400);
    localparam int DIV3 = (CLK_FREQ + 8*57600)  / (16*57600);
    localparam int DIV4 = (CLK_FREQ + 8*115200) / (16*115200);
    localparam int DIV5 = (CLK_FREQ + 8*230400) / (16*230400);
    localparam int DW   = $clog2(DIV0 + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q, rx_d_q;
    logic [DW-1:0]   div_q, div_d, cnt_q, cnt_d, div_sel;
    logic [3:0]      samp_q, samp_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      cap_q, cap_d;
    logic [7:0]      shift_q, shift_d, data_q, data_d;
    logic            done_q, done_d, ferr_q, ferr_d;
    logic            tick, maj, decide, bit_end;

    always_comb begin
        case (baud_set)
            3'd0:    div_sel = DW'(DIV0);
            3'd1:    div_sel = DW'(DIV1);
            3'd2:    div_sel = DW'(DIV2);
            3'd3:    div_sel = DW'(DIV3);
            3'd5:    div_sel = DW'(DIV5);
            default: div_sel = DW'(DIV4);
        endcase
    end

    assign tick    = (state_q != IDLE) && (cnt_q == div_q - 1'b1);
    // Captures at s=6,7 are stored; the s=8 capture is the live rx_s.
    assign maj     = (cap_q[0] & cap_q[1]) | (cap_q[0] & rx_s_q) | (cap_q[1] & rx_s_q);
    assign decide  = tick && (samp_q == 4'd8);
    assign bit_end = tick && (samp_q == 4'd15);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        cap_d   = cap_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        if (!rx_en) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (rx_d_q && !rx_s_q) begin
                state_d = START;
                div_d   = div_sel;
                cnt_d   = '0;
                samp_d  = '0;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                samp_d = samp_q + 1'b1;
                if (samp_q == 4'd6) cap_d[0] = rx_s_q;
                if (samp_q == 4'd7) cap_d[1] = rx_s_q;
            end
            case (state_q)
                START: begin
                    if (decide && maj) state_d = IDLE;
                    else if (bit_end) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (decide) shift_d = {maj, shift_q[7:1]};
                    if (bit_end) begin
                        if (bit_q == 3'd7) state_d = STOP;
                        else               bit_d   = bit_q + 1'b1;
                    end
                end
                STOP: begin
                    // Leave mid stop bit so the next start edge is not missed.
                    if (decide) begin
                        data_d  = shift_q;
                        done_d  = maj;
                        ferr_d  = !maj;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
            state_q   <= IDLE;
            div_q     <= DW'(DIV4);
            cnt_q     <= '0;
            samp_q    <= '0;
            bit_q     <= '0;
            cap_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            cap_q     <= cap_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data_byte  = data_q;
    assign rx_done    = done_q;
    assign frame_err  = ferr_q;
    assign uart_state = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. Runs the receiver at 12.5 MHz so 9600-baud
// frames stay short: DIV = 81 (9600), 7 (115200), 3 (230400).
module tb_uart_rx;
    localparam int BIT0 = 16*81;   // clk per bit, baud_set 0
    localparam int BIT4 = 16*7;    // clk per bit, baud_set 4
    localparam int BIT5 = 16*3;    // clk per bit, baud_set 5

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_en = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic       rx = 1'b1;
    logic [7:0] data_byte;
    logic       rx_done, frame_err, uart_state;

    int n_chk = 0, n_fail = 0;
    int done_cnt = 0, ferr_cnt = 0, both_cnt = 0, st_cnt = 0;
    logic [7:0] last_data = 8'h00;
    int d0, f0;

    uart_rx #(.CLK_FREQ(12500000)) dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .baud_set(baud_set), .rx(rx),
        .data_byte(data_byte), .rx_done(rx_done), .frame_err(frame_err),
        .uart_state(uart_state)
    );

    always #40 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            last_data = data_byte;
        end
        if (frame_err) ferr_cnt++;
        if (rx_done && frame_err) both_cnt++;
        if (uart_state) st_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int bitclk);
        rx = 1'b0;
        repeat (bitclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bitclk) @(negedge clk);
        end
        rx = stop;
        repeat (bitclk) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", data_byte, 8'h00);
        chk("rst_done", rx_done, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_state", uart_state, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 0xA5 at 115200: 153 ticks of 7 clk in frame = 1071 clk busy
        baud_set = 3'd4;
        d0 = done_cnt; f0 = ferr_cnt; st_cnt = 0;
        send(8'hA5, 1'b1, BIT4);
        repeat (20) @(negedge clk);
        chk("a5_done", done_cnt - d0, 1);
        chk("a5_data", last_data, 8'hA5);
        chk("a5_ferr", ferr_cnt - f0, 0);
        chk("a5_busy", (st_cnt >= 1065 && st_cnt <= 1077), 1'b1);
        chk("a5_idle", uart_state, 1'b0);

        // back-to-back at 9600
        baud_set = 3'd0;
        d0 = done_cnt;
        send(8'h00, 1'b1, BIT0);
        chk("b2b_first", last_data, 8'h00);
        send(8'hFF, 1'b1, BIT0);
        repeat (20) @(negedge clk);
        chk("b2b_done", done_cnt - d0, 2);
        chk("b2b_second", last_data, 8'hFF);

        // 100 ns glitch: false start after 9 ticks (~63 clk)
        baud_set = 3'd4;
        d0 = done_cnt; f0 = ferr_cnt; st_cnt = 0;
        rx = 1'b0; #100; rx = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_done", done_cnt - d0, 0);
        chk("glitch_ferr", ferr_cnt - f0, 0);
        chk("glitch_busy", (st_cnt >= 60 && st_cnt <= 66), 1'b1);
        chk("glitch_data", data_byte, 8'hFF);

        // framing error at 230400, then break, then recovery
        baud_set = 3'd5;
        d0 = done_cnt; f0 = ferr_cnt;
        send(8'h3C, 1'b0, BIT5);
        chk("ferr_pulse", ferr_cnt - f0, 1);
        chk("ferr_nodone", done_cnt - d0, 0);
        chk("ferr_data", data_byte, 8'h3C);
        repeat (3*BIT5) @(negedge clk);
        chk("break_quiet", done_cnt - d0, 0);
        rx = 1'b1;
        repeat (BIT5) @(negedge clk);
        send(8'h55, 1'b1, BIT5);
        repeat (10) @(negedge clk);
        chk("rec_done", done_cnt - d0, 1);
        chk("rec_data", last_data, 8'h55);

        // reset during DATA bit 4 (bit 4 spans 560..671 clk after start)
        baud_set = 3'd4;
        d0 = done_cnt; f0 = ferr_cnt;
        fork
            send(8'hE7, 1'b1, BIT4);
            begin
                repeat (600) @(negedge clk);
                reset = 1'b1;
                #1;
                chk("mid_rst_data", data_byte, 8'h00);
                chk("mid_rst_state", uart_state, 1'b0);
                chk("mid_rst_done", rx_done, 1'b0);
            end
        join
        chk("mid_rst_nopulse", (done_cnt - d0) + (ferr_cnt - f0), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        send(8'h81, 1'b1, BIT4);
        repeat (10) @(negedge clk);
        chk("post_rst_data", last_data, 8'h81);
        chk("post_rst_done", done_cnt - d0, 1);

        // baud_set changed mid-frame is ignored until next start
        d0 = done_cnt;
        fork
            send(8'hC3, 1'b1, BIT4);
            begin
                repeat (300) @(negedge clk);
                baud_set = 3'd0;
            end
        join
        repeat (10) @(negedge clk);
        chk("chg_data", last_data, 8'hC3);
        send(8'h5A, 1'b1, BIT0);
        repeat (10) @(negedge clk);
        chk("chg_next_data", last_data, 8'h5A);
        chk("chg_done", done_cnt - d0, 2);

        chk("never_both", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
